rc4_phase_controller: RTL and testbench

//  Top-level sequencer for the s_memory datapath. Runs the init, shuffle and decode FSMs in order

---
 rtl/rc4_phase_controller.sv | 96 +++++++++
 tb/tb_rc4_phase_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rc4_phase_controller.sv
// rc4_phase_controller: sequences init/shuffle/decode over s_memory; define RC4_KEY_SEARCH_EN to step the key after a failed decode
module rc4_phase_controller #(
    parameter int KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX = 24'h3FFFFF,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 init_start,
    input  logic                 init_done,
    output logic                 shuffle_start,
    input  logic                 shuffle_done,
    output logic                 decode_start,
    input  logic                 decode_done,
    input  logic                 decode_success,
    output logic [1:0]           select_share,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 success,
    output logic                 fail
);
`ifdef RC4_KEY_SEARCH_EN
    localparam bit SEARCH_EN = 1'b1;
`else
    localparam bit SEARCH_EN = 1'b0;
`endif
    localparam int CW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, INIT_RUN, GAP_A, SHUF_RUN, GAP_B, DEC_RUN, GAP_C, PASS, FAIL
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] gap_cnt;
    logic [KEY_WIDTH-1:0] key_nx;
    logic gap_end;

    always_comb begin
        gap_end = gap_cnt == '0;
        state_nx = state;
        key_nx = secret_key;
        case (state)
            IDLE, PASS, FAIL: begin
                state_nx = start ? INIT_RUN : state;
                key_nx = start ? '0 : secret_key;
            end
            INIT_RUN: state_nx = (!init_start && init_done) ? GAP_A : INIT_RUN;
            GAP_A:    state_nx = gap_end ? SHUF_RUN : GAP_A;
            SHUF_RUN: state_nx = (!shuffle_start && shuffle_done) ? GAP_B : SHUF_RUN;
            GAP_B:    state_nx = gap_end ? DEC_RUN : GAP_B;
            DEC_RUN: begin
                if (!decode_start && decode_done) begin
                    if (decode_success) begin
                        state_nx = PASS;
                    end else if (SEARCH_EN && secret_key < KEY_MAX) begin
                        state_nx = GAP_C;
                        key_nx = secret_key + 1'b1;
                    end else begin
                        state_nx = FAIL;
                    end
                end
            end
            GAP_C:    state_nx = gap_end ? INIT_RUN : GAP_C;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gap_cnt <= '0;
            init_start <= 1'b0;
            shuffle_start <= 1'b0;
            decode_start <= 1'b0;
            select_share <= 2'b00;
            secret_key <= '0;
            busy <= 1'b0;
            success <= 1'b0;
            fail <= 1'b0;
        end else begin
            state <= state_nx;
            secret_key <= key_nx;
            gap_cnt <= (state_nx != state) ? CW'(GAP_CYCLES - 1) : gap_end ? gap_cnt : gap_cnt - 1'b1;
            init_start <= state_nx == INIT_RUN && state != INIT_RUN;
            shuffle_start <= state_nx == SHUF_RUN && state != SHUF_RUN;
            decode_start <= state_nx == DEC_RUN && state != DEC_RUN;
            select_share <= state_nx == INIT_RUN ? 2'b01 :
                            state_nx == SHUF_RUN ? 2'b10 :
                            state_nx == DEC_RUN  ? 2'b11 : 2'b00;
            busy <= !(state_nx inside {IDLE, PASS, FAIL});
            success <= state_nx == PASS;
            fail <= state_nx == FAIL;
        end
    end
endmodule

// File: tb/tb_rc4_phase_controller.sv
// tb_rc4_phase_controller: scoreboard bench for the phase sequencer (KEY_MAX=3, GAP_CYCLES=2)
module tb_rc4_phase_controller;
    logic clk = 1'b0;
    logic reset, start, init_done, shuffle_done, decode_done, decode_success;
    logic init_start, shuffle_start, decode_start, busy, success, fail;
    logic [1:0] select_share;
    logic [23:0] secret_key;
    int tests = 0;
    int fails = 0;
    logic [5:0] exp_q[$];
    logic [23:0] key_q[$];

    always #5 clk = ~clk;

    rc4_phase_controller #(.KEY_WIDTH(24), .KEY_MAX(24'd3), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .init_start(init_start), .init_done(init_done),
        .shuffle_start(shuffle_start), .shuffle_done(shuffle_done),
        .decode_start(decode_start), .decode_done(decode_done), .decode_success(decode_success),
        .select_share(select_share), .secret_key(secret_key),
        .busy(busy), .success(success), .fail(fail)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        tests++;
        if ({busy, init_start, shuffle_start, decode_start, select_share, success, fail} !== 8'b0 || secret_key !== 24'd0) begin
            fails++;
            $display("FAIL %s: busy=%b starts=%b%b%b sel=%b succ=%b fail=%b key=%0d, required all zero",
                     name, busy, init_start, shuffle_start, decode_start, select_share, success, fail, secret_key);
        end
    endtask

    task automatic push_pass(input int init_len, input int dly, input int attempts);
        for (int a = 0; a < attempts; a++) begin
            exp_q.push_back(6'b1_100_01);
            for (int i = 1; i < init_len; i++) exp_q.push_back(6'b1_000_01);
            repeat (2) exp_q.push_back(6'b1_000_00);
            exp_q.push_back(6'b1_010_10);
            for (int i = 1; i < dly; i++) exp_q.push_back(6'b1_000_10);
            repeat (2) exp_q.push_back(6'b1_000_00);
            exp_q.push_back(6'b1_001_11);
            for (int i = 1; i < dly; i++) exp_q.push_back(6'b1_000_11);
            if (a < attempts - 1) repeat (2) exp_q.push_back(6'b1_000_00);
            key_q.push_back(24'(a));
        end
        exp_q.push_back(6'b0_000_00);
    endtask

    task automatic run_pass(input string name, input bit early, input int dly, input logic [7:0] outs,
                            input int attempts, input bit start_in_dec, input bit exp_ok, input logic [23:0] exp_key);
        int ph = 0;
        int rc = 0;
        int att = 0;
        bit cur = 1'b0;
        logic [5:0] e, got;
        logic [23:0] k;
        exp_q.delete();
        key_q.delete();
        push_pass(early ? 2 : dly, dly, attempts);
        init_done = early;
        shuffle_done = 1'b0;
        decode_done = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {busy, init_start, shuffle_start, decode_start, select_share};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL %s trace: busy/starts/sel=%b required %b", name, got, e);
            end
            if (decode_start) begin
                k = key_q.size() > 0 ? key_q.pop_front() : 24'hxxxxxx;
                tests++;
                if (secret_key !== k) begin
                    fails++;
                    $display("FAIL %s decode key: got %0d required %0d", name, secret_key, k);
                end
                cur = att < 8 ? outs[att] : 1'b1;
                att++;
            end
            if (exp_q.size() == 0) break;
            if (init_start) begin ph = 1; rc = 0; end
            else if (shuffle_start) begin ph = 2; rc = 0; end
            else if (decode_start) begin ph = 3; rc = 0; end
            else rc++;
            init_done = early || (ph == 1 && rc == dly - 1);
            shuffle_done = ph == 2 && rc == dly - 1;
            decode_done = ph == 3 && rc == dly - 1;
            decode_success = decode_done ? cur : 1'($urandom);
            start = start_in_dec && ph == 3;
            tick;
        end
        start = 1'b0;
        init_done = 1'b0;
        shuffle_done = 1'b0;
        decode_done = 1'b0;
        tests++;
        if ({success, fail} !== {exp_ok, !exp_ok} || secret_key !== exp_key) begin
            fails++;
            $display("FAIL %s final: succ=%b fail=%b key=%0d required succ=%b fail=%b key=%0d",
                     name, success, fail, secret_key, exp_ok, !exp_ok, exp_key);
        end
        tests++;
        if (key_q.size() != 0) begin
            fails++;
            $display("FAIL %s decode count: %0d decode_start pulses missing, required 0", name, key_q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        init_done = 1'b0;
        shuffle_done = 1'b0;
        decode_done = 1'b0;
        decode_success = 1'b0;
        repeat (3) tick;
        check_idle("reset_held");
        reset = 1'b0;
        tick;
        check_idle("idle_after_reset");
    endtask

    task automatic test_happy_path;
        run_pass("happy", 1'b0, 5, 8'b1, 1, 1'b0, 1'b1, 24'd0);
    endtask

    task automatic test_early_done;
        run_pass("early_done", 1'b1, 3, 8'b1, 1, 1'b0, 1'b1, 24'd0);
    endtask

`ifdef RC4_KEY_SEARCH_EN
    task automatic test_key_search;
        run_pass("search_pass", 1'b0, 3, 8'b1000, 4, 1'b0, 1'b1, 24'd3);
        run_pass("search_fail", 1'b0, 2, 8'b0000, 4, 1'b0, 1'b0, 24'd3);
    endtask
`else
    task automatic test_no_search;
        run_pass("no_search", 1'b0, 3, 8'b0, 1, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++;
            if (init_start !== 1'b0 || fail !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL no_search hold: init_start=%b fail=%b busy=%b required 0,1,0", init_start, fail, busy);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_shuffle;
        int n = 0;
        init_done = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (!shuffle_start && n < 20) begin
            tick;
            n++;
        end
        tests++;
        if (!shuffle_start) begin
            fails++;
            $display("FAIL mid_shuffle wait: shuffle_start=%b after %0d cycles, required 1", shuffle_start, n);
        end
        init_done = 1'b0;
        repeat (2) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_idle("reset_mid_shuffle");
        tick;
        check_idle("idle_after_abort");
        run_pass("restart_start_in_dec", 1'b0, 4, 8'b1, 1, 1'b1, 1'b1, 24'd0);
    endtask

    task automatic test_back_to_back;
        run_pass("back_to_back", 1'b0, 2, 8'b1, 1, 1'b0, 1'b1, 24'd0);
    endtask

    initial begin
        test_reset;
        test_happy_path;
        test_early_done;
`ifdef RC4_KEY_SEARCH_EN
        test_key_search;
`else
        test_no_search;
`endif
        test_reset_mid_shuffle;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
